mul_div_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO result registers.
- Sits beside the combinational ALU in the execute stage and extends the datapath with signed and unsigned mult/div plus HI/LO moves.
- Reports `busy` so the hazard unit can stall HI/LO readers and new mult/div issues for a fixed, parameter-set latency.

---
 rtl/mul_div_unit.sv | 147 ++++++++++++++
 tb/tb_mul_div_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers for the execute stage.
// Define MUL_DIV_UNIT_DIV_EN to include div/divu; without it ops 010/011 are no-ops.
module mul_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
`ifdef MUL_DIV_UNIT_DIV_EN
        S_DIV,
`endif
        S_MULT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    // Product of the captured operands, extended to 2*WIDTH according to signedness.
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    assign a_ext = sign_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign b_ext = sign_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod  = a_ext * b_ext;

`ifdef MUL_DIV_UNIT_DIV_EN
    // Sign-magnitude divide; MIN / -1 falls out as quotient MIN, remainder 0.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
    assign a_neg = sign_q & a_q[WIDTH-1];
    assign b_neg = sign_q & b_q[WIDTH-1];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem   = a_neg ? -r_mag : r_mag;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        // NOTE: every next-state value defaults to its register so no path infers a latch.
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'b000, 3'b001: begin
                            state_d = S_MULT;
                            count_d = CNT_W'(MULT_CYCLES);
                            a_d     = A;
                            b_d     = B;
                            sign_d  = ~op[0];
                        end
`ifdef MUL_DIV_UNIT_DIV_EN
                        3'b010, 3'b011: begin
                            state_d = S_DIV;
                            count_d = CNT_W'(DIV_CYCLES);
                            a_d     = A;
                            b_d     = B;
                            sign_d  = ~op[0];
                        end
`endif
                        3'b100:  hi_d = A;
                        3'b101:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_MULT: begin
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    {hi_d, lo_d} = prod;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end
            end
`ifdef MUL_DIV_UNIT_DIV_EN
            S_DIV: begin
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    // A zero divisor still completes and pulses done but leaves HI/LO alone.
                    if (b_q != '0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32, 5 mult / 10 div cycles).
// Div checks run only when MUL_DIV_UNIT_DIV_EN is defined; otherwise the no-op path is checked.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
    endtask

    // Count busy cycles (bounded) and land in the done cycle.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (busy && cycles < 50) begin
            cycles++;
            tick();
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cycles;
        issue(o, a, b);
        wait_done(cycles);
        check({tag, "_busy_cycles"}, 64'(cycles), 64'(n));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        tick();
        check({tag, "_done_drop"}, 64'(done), 64'd0);
    endtask

    task automatic reset_midop(input string tag, input logic [2:0] o);
        int done_seen;
        issue(o, 32'd9, 32'd3);
        tick();
        tick();
        tick();
        check({tag, "_busy_before_reset"}, 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check({tag, "_busy_after_reset"}, 64'(busy), 64'd0);
        check({tag, "_hi_after_reset"}, 64'(hi), 64'd0);
        check({tag, "_lo_after_reset"}, 64'(lo), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_seen++;
            tick();
        end
        check({tag, "_no_done_after_reset"}, 64'(done_seen), 64'd0);
    endtask

    initial begin
        int cycles;

        // Reset, with a start in the same cycle that must be ignored.
        reset = 1'b1;
        start = 1'b1;
        op    = 3'b100;
        A     = 32'hAAAA_5555;
        tick();
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);

        run_op("mult_neg", 3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'h0000_0001, 32'hFFFF_FFFE);

        // HI/LO moves: visible next cycle, no busy, no done.
        issue(3'b100, 32'h0000_1234, 32'h0);
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_busy", 64'(busy), 64'd0);
        issue(3'b101, 32'h0000_5678, 32'h0);
        check("mtlo_lo", 64'(lo), 64'h5678);
        check("mtlo_hi_kept", 64'(hi), 64'h1234);
        check("mtlo_done", 64'(done), 64'd0);

        // Reserved op is ignored.
        issue(3'b110, 32'hFFFF_0000, 32'h1);
        check("nop_busy", 64'(busy), 64'd0);
        check("nop_hi", 64'(hi), 64'h1234);
        check("nop_lo", 64'(lo), 64'h5678);

`ifdef MUL_DIV_UNIT_DIV_EN
        issue(3'b101, 32'h0000_5678, 32'h0);
        run_op("divu_by0", 3'b011, 32'h0000_0777, 32'h0, 10, 32'h0000_1234, 32'h0000_5678);
        run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'b011, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_big", 3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'h0000_0001, 32'h7FFF_FFFC);
`else
        issue(3'b010, 32'h0000_0007, 32'h0000_0002);
        check("nodiv_busy", 64'(busy), 64'd0);
        tick();
        check("nodiv_done", 64'(done), 64'd0);
        check("nodiv_hi", 64'(hi), 64'h1234);
        check("nodiv_lo", 64'(lo), 64'h5678);
        issue(3'b011, 32'h0000_0007, 32'h0);
        check("nodivu_busy", 64'(busy), 64'd0);
`endif

        // Start while busy (mtlo) is ignored; operand changes after issue have no effect.
        issue(3'b000, 32'h0000_0003, 32'h0000_0004);
        start = 1'b1;
        op    = 3'b101;
        A     = 32'h0000_DEAD;
        B     = 32'h0000_0100;
        tick();
        start = 1'b0;
        A     = 32'h1111_1111;
        tick();
        check("busy_mtlo_lo", 64'(lo), 64'h5678);
        wait_done(cycles);
        check("captured_cycles", 64'(cycles), 64'd3);
        check("captured_done", 64'(done), 64'd1);
        check("captured_hi", 64'(hi), 64'd0);
        check("captured_lo", 64'(lo), 64'd12);

        // Back-to-back issue in the done cycle: -3 * 5 = -15.
        issue(3'b000, 32'hFFFF_FFFD, 32'h0000_0005);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done(cycles);
        check("b2b_cycles", 64'(cycles), 64'd5);
        check("b2b_hi", 64'(hi), 64'hFFFF_FFFF);
        check("b2b_lo", 64'(lo), 64'hFFFF_FFF1);
        tick();

`ifdef MUL_DIV_UNIT_DIV_EN
        reset_midop("div_reset", 3'b010);
`else
        reset_midop("mult_reset", 3'b000);
`endif

        run_op("mult_after_reset", 3'b000, 32'h0001_0000, 32'h0001_0000, 5, 32'h0000_0001, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
